// File: rtl/sdrc_bank_arb_pkg.sv
// rtl/sdrc_bank_arb_pkg.sv - shared op codes, arbiter states and bank constants
package sdrc_bank_arb_pkg;

  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 13;

  typedef enum logic [1:0] {
    OP_PRE = 2'd0,
    OP_ACT = 2'd1,
    OP_RD  = 2'd2,
    OP_WR  = 2'd3
  } sdr_op_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] idx);
    return {{(NUM_BANKS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/sdrc_rr_pick.sv
// rtl/sdrc_rr_pick.sv - rotating-priority pick: first requester after ptr, skipping excluded banks
module sdrc_rr_pick
  import sdrc_bank_arb_pkg::*;
(
  input  logic [NUM_BANKS-1:0] req,
  input  logic [1:0]           ptr,
  input  logic [NUM_BANKS-1:0] excl,
  output logic                 valid,
  output logic [1:0]           idx
);

  logic [NUM_BANKS-1:0] cand;
  logic [1:0]           probe;

  // Walk from farthest to nearest so the bank right after ptr overrides the rest.
  always_comb begin
    cand  = req & ~excl;
    valid = 1'b0;
    idx   = '0;
    probe = '0;
    for (int k = NUM_BANKS; k >= 1; k--) begin
      probe = ptr + 2'(k);
      if (cand[probe]) begin
        valid = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/sdrc_bank_arb.sv
// rtl/sdrc_bank_arb.sv - four-bank command arbiter presenting one registered command to xfr_ctl
// Optional starvation aging enabled by defining SDRC_ARB_AGE_EN.
module sdrc_bank_arb
  import sdrc_bank_arb_pkg::*;
#(
  parameter int SDR_REQ_ID_W = 4,
  parameter int REQ_BW       = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_BANKS-1:0]             b2a_req,
  input  logic [2*NUM_BANKS-1:0]           b2a_cmd,
  input  logic [ADDR_W*NUM_BANKS-1:0]      b2a_addr,
  input  logic [SDR_REQ_ID_W*NUM_BANKS-1:0] b2a_id,
  input  logic [REQ_BW*NUM_BANKS-1:0]      b2a_len,
  input  logic [NUM_BANKS-1:0]             b2a_start,
  input  logic [NUM_BANKS-1:0]             b2a_last,
  input  logic [NUM_BANKS-1:0]             b2a_wrap,
  output logic [NUM_BANKS-1:0]             a2b_ack,
  output logic                             a2x_req,
  output logic [1:0]                       a2x_bank,
  output logic [1:0]                       a2x_cmd,
  output logic [ADDR_W-1:0]                a2x_addr,
  output logic [SDR_REQ_ID_W-1:0]          a2x_id,
  output logic [REQ_BW-1:0]                a2x_len,
  output logic                             a2x_start,
  output logic                             a2x_last,
  output logic                             a2x_wrap,
  input  logic                             x2a_ack,
  input  logic                             x2a_refresh,
  input  logic [3:0]                       age_limit
);

  arb_state_e           state, state_nxt;
  logic [1:0]           rr_ptr;
  logic                 ack_ok, abort, load;
  logic [1:0]           pick_ptr;
  logic [NUM_BANKS-1:0] pick_excl;
  logic                 rr_valid, aged_valid, win_valid;
  logic [1:0]           rr_idx, aged_idx, win_idx;

  // On an ack cycle the next pick rotates from the acked bank and skips it.
  always_comb begin
    ack_ok    = (state == ARB_BUSY) && x2a_ack;
    abort     = (state == ARB_BUSY) && !x2a_ack && (!b2a_req[a2x_bank] || x2a_refresh);
    pick_ptr  = ack_ok ? a2x_bank : rr_ptr;
    pick_excl = ack_ok ? bank_onehot(a2x_bank) : '0;
  end

  sdrc_rr_pick u_rr_pick (
    .req   (b2a_req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

`ifdef SDRC_ARB_AGE_EN
  logic [3:0] age_cnt [NUM_BANKS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (reset || !b2a_req[i] || a2b_ack[i]) begin
        age_cnt[i] <= 4'd0;
      end else if (age_cnt[i] != 4'hF) begin
        age_cnt[i] <= age_cnt[i] + 4'd1;
      end
    end
  end

  // Starved banks override round-robin; lowest index wins among them.
  always_comb begin
    aged_valid = 1'b0;
    aged_idx   = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if ((age_limit != 4'd0) && b2a_req[i] && !pick_excl[i] && (age_cnt[i] >= age_limit)) begin
        aged_valid = 1'b1;
        aged_idx   = 2'(i);
      end
    end
  end
`else
  logic age_unused;
  assign age_unused = ^age_limit;
  assign aged_valid = 1'b0;
  assign aged_idx   = '0;
`endif

  assign win_valid = aged_valid | rr_valid;
  assign win_idx   = aged_valid ? aged_idx : rr_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (win_valid) state_nxt = ARB_BUSY;
      ARB_BUSY: begin
        if (ack_ok)     state_nxt = win_valid ? ARB_BUSY : ARB_IDLE;
        else if (abort) state_nxt = ARB_IDLE;
      end
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // A reset landing on an ack cycle drops the command without acknowledging it.
  always_comb begin
    a2b_ack = '0;
    load    = 1'b0;
    case (state)
      ARB_IDLE: load = win_valid;
      ARB_BUSY: begin
        if (ack_ok && !reset) a2b_ack = bank_onehot(a2x_bank);
        load = ack_ok && win_valid;
      end
      default: ;
    endcase
  end

  assign a2x_req = (state == ARB_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= 2'd3;
      a2x_bank  <= '0;
      a2x_cmd   <= '0;
      a2x_addr  <= '0;
      a2x_id    <= '0;
      a2x_len   <= '0;
      a2x_start <= 1'b0;
      a2x_last  <= 1'b0;
      a2x_wrap  <= 1'b0;
    end else begin
      if (ack_ok) rr_ptr <= a2x_bank;
      if (load) begin
        a2x_bank  <= win_idx;
        a2x_cmd   <= b2a_cmd[2*int'(win_idx) +: 2];
        a2x_addr  <= b2a_addr[ADDR_W*int'(win_idx) +: ADDR_W];
        a2x_id    <= b2a_id[SDR_REQ_ID_W*int'(win_idx) +: SDR_REQ_ID_W];
        a2x_len   <= b2a_len[REQ_BW*int'(win_idx) +: REQ_BW];
        a2x_start <= b2a_start[win_idx];
        a2x_last  <= b2a_last[win_idx];
        a2x_wrap  <= b2a_wrap[win_idx];
      end
    end
  end

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// tb/tb_sdrc_bank_arb.sv - directed and randomized checks of sdrc_bank_arb against a behavioural model
// Aging expectations follow SDRC_ARB_AGE_EN when it is defined for the build.
module tb_sdrc_bank_arb;
  import sdrc_bank_arb_pkg::*;

  localparam int IDW = 4;
  localparam int LW  = 12;
  localparam int FW  = 2 + 13 + IDW + LW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [3:0]        b2a_req, b2a_start, b2a_last, b2a_wrap;
  logic [7:0]        b2a_cmd;
  logic [51:0]       b2a_addr;
  logic [4*IDW-1:0]  b2a_id;
  logic [4*LW-1:0]   b2a_len;
  logic [3:0]        a2b_ack;
  logic              a2x_req, a2x_start, a2x_last, a2x_wrap;
  logic [1:0]        a2x_bank, a2x_cmd;
  logic [12:0]       a2x_addr;
  logic [IDW-1:0]    a2x_id;
  logic [LW-1:0]     a2x_len;
  logic              x2a_ack, x2a_refresh;
  logic [3:0]        age_limit;

  sdrc_bank_arb #(.SDR_REQ_ID_W(IDW), .REQ_BW(LW)) dut (
    .clk(clk), .reset(reset),
    .b2a_req(b2a_req), .b2a_cmd(b2a_cmd), .b2a_addr(b2a_addr), .b2a_id(b2a_id),
    .b2a_len(b2a_len), .b2a_start(b2a_start), .b2a_last(b2a_last), .b2a_wrap(b2a_wrap),
    .a2b_ack(a2b_ack), .a2x_req(a2x_req), .a2x_bank(a2x_bank), .a2x_cmd(a2x_cmd),
    .a2x_addr(a2x_addr), .a2x_id(a2x_id), .a2x_len(a2x_len), .a2x_start(a2x_start),
    .a2x_last(a2x_last), .a2x_wrap(a2x_wrap), .x2a_ack(x2a_ack),
    .x2a_refresh(x2a_refresh), .age_limit(age_limit)
  );

  int checks = 0;
  int errors = 0;

  bit             m_busy;
  int             m_bank, m_ptr;
  logic [FW-1:0]  m_fields;
  int             m_age [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] fields_of(input int b);
    return {b2a_cmd[2*b +: 2], b2a_addr[13*b +: 13], b2a_id[IDW*b +: IDW],
            b2a_len[LW*b +: LW], b2a_start[b], b2a_last[b], b2a_wrap[b]};
  endfunction

  // Requesting bank chosen by the arbitration rules; -1 when nobody qualifies.
  function automatic int choose(input int ptr, input int excl);
`ifdef SDRC_ARB_AGE_EN
    if (age_limit != 0)
      for (int b = 0; b < 4; b++)
        if (b2a_req[b] && b != excl && m_age[b] >= int'(age_limit)) return b;
`endif
    for (int k = 1; k <= 4; k++) begin
      int b;
      b = (ptr + k) % 4;
      if (b2a_req[b] && b != excl) return b;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ack();
    if (m_busy && x2a_ack && !reset) return 4'b0001 << m_bank;
    return 4'b0000;
  endfunction

  task automatic model_update();
    logic [3:0] ack;
    int w;
    ack = exp_ack();
    w = -1;
    if (reset) begin
      m_busy = 0; m_bank = 0; m_ptr = 3; m_fields = '0;
      foreach (m_age[b]) m_age[b] = 0;
    end else begin
      if (m_busy && x2a_ack) begin
        m_ptr  = m_bank;
        w      = choose(m_ptr, m_bank);
        m_busy = (w >= 0);
      end else if (m_busy && (!b2a_req[m_bank] || x2a_refresh)) begin
        m_busy = 0;
      end else if (!m_busy) begin
        w      = choose(m_ptr, -1);
        m_busy = (w >= 0);
      end
      if (w >= 0) begin
        m_bank   = w;
        m_fields = fields_of(w);
      end
      foreach (m_age[b])
        m_age[b] = (!b2a_req[b] || ack[b]) ? 0 : ((m_age[b] < 15) ? m_age[b] + 1 : 15);
    end
  endtask

  task automatic check_model();
    chk("a2x_req", a2x_req, m_busy);
    chk("a2x_bank", a2x_bank, m_bank[1:0]);
    chk("a2x_fields", {a2x_cmd, a2x_addr, a2x_id, a2x_len, a2x_start, a2x_last, a2x_wrap}, m_fields);
    chk("a2b_ack", a2b_ack, exp_ack());
    chk("a2b_ack_onehot", ($countones(a2b_ack) <= 1), 1);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    b2a_cmd   = 8'($urandom);
    b2a_addr  = 52'({$urandom, $urandom});
    b2a_id    = 16'($urandom);
    b2a_len   = 48'({$urandom, $urandom});
    b2a_start = 4'($urandom);
    b2a_last  = 4'($urandom);
    b2a_wrap  = 4'($urandom);
  endtask

  task automatic do_reset();
    reset = 1; b2a_req = 0; x2a_ack = 0; x2a_refresh = 0;
    cyc(); adv();
    reset = 0;
  endtask

  initial begin
    int exp_b;
    reset = 1; b2a_req = 0; x2a_ack = 0; x2a_refresh = 0; age_limit = 0;
    rand_fields();
    adv(); adv();
    cyc();
    chk("reset_req", a2x_req, 0);
    chk("reset_fields", {a2x_bank, a2x_cmd, a2x_addr, a2x_id, a2x_len, a2x_start, a2x_last, a2x_wrap}, 0);
    adv();

    // All banks requesting, xfr_ctl acking every busy cycle
    reset = 0; b2a_req = 4'hF; x2a_ack = 1;
    cyc(); chk("rr_idle_req", a2x_req, 0); adv();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_seq_bank", a2x_bank, k % 4);
      chk("rr_seq_ack", a2b_ack, 4'b0001 << (k % 4));
      adv();
    end

    // Single ACT from bank 2
    do_reset();
    b2a_req = 4'b0100; rand_fields();
    b2a_cmd[5:4] = OP_ACT; b2a_addr[38:26] = 13'h0155;
    cyc(); chk("act_idle", a2x_req, 0); adv();
    x2a_ack = 1;
    cyc();
    chk("act_req", a2x_req, 1);
    chk("act_cmd", a2x_cmd, OP_ACT);
    chk("act_addr", a2x_addr, 13'h0155);
    chk("act_ack", a2b_ack, 4'b0100);
    adv();
    x2a_ack = 0; b2a_req = 0;
    cyc(); chk("act_back_idle", a2x_req, 0); adv();

    // Bank 1 withdraws before ack; pointer must stay at 0
    do_reset();
    b2a_req = 4'b0001; cyc(); adv();
    x2a_ack = 1; cyc(); chk("ptr_setup_ack", a2b_ack, 4'b0001); adv();
    b2a_req = 4'b0010; x2a_ack = 0; cyc(); adv();
    b2a_req = 4'b0000;
    cyc(); chk("drop_busy", a2x_req, 1); chk("drop_noack", a2b_ack, 0); adv();
    b2a_req = 4'b1110;
    cyc(); chk("drop_idle", a2x_req, 0); adv();
    cyc(); chk("drop_next_bank", a2x_bank, 1); adv();

    // Refresh with ack completes; refresh alone aborts
    x2a_ack = 1; x2a_refresh = 1;
    cyc(); chk("refack_ack", a2b_ack, 4'b0010); adv();
    x2a_ack = 0;
    cyc(); chk("refresh_busy_bank", a2x_bank, 2); chk("refresh_noack", a2b_ack, 0); adv();
    x2a_refresh = 0;
    cyc(); chk("refresh_idle", a2x_req, 0); adv();

    // Reset while busy
    reset = 1; x2a_ack = 1;
    cyc(); chk("rst_busy_req", a2x_req, 1); chk("rst_busy_noack", a2b_ack, 0); adv();
    reset = 0; x2a_ack = 0; b2a_req = 4'hF;
    cyc(); chk("rst_after_req", a2x_req, 0); chk("rst_after_ack", a2b_ack, 0); adv();
    cyc(); chk("rst_first_req", a2x_req, 1); chk("rst_first_bank", a2x_bank, 0); adv();

    // Starved bank 3 versus round-robin choice of bank 1
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      age_limit = (pass == 0) ? 4'd3 : 4'd0;
      b2a_req = 4'b1001; x2a_ack = 0;
      repeat (4) begin cyc(); adv(); end
      b2a_req = 4'b1011; x2a_ack = 1;
      cyc(); chk("age_ack0", a2b_ack, 4'b0001); adv();
      x2a_ack = 0;
      exp_b = 1;
`ifdef SDRC_ARB_AGE_EN
      if (pass == 0) exp_b = 3;
`endif
      cyc(); chk("age_grant", a2x_bank, exp_b); adv();
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 150 == 0) age_limit = 4'($urandom_range(0, 15) > 10 ? $urandom_range(0, 15) : $urandom_range(0, 4));
      if ($urandom_range(0, 9) < 4) b2a_req = 4'($urandom);
      x2a_ack     = ($urandom_range(0, 2) == 0);
      x2a_refresh = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      rand_fields();
      cyc(); adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrc_bank_arb.md
SDRC_BANK_ARB -- requirements
Module: sdrc_bank_arb

Interface
REQ-001 SHALL have parameter SDR_REQ_ID_W, default 4: request ID width.
REQ-002 SHALL have parameter REQ_BW, default 12: transfer length width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports b2a_req, input, 4: per-bank command request from the bank FSMs.
REQ-006 SHALL have ports b2a_cmd, input, 4x2 (8): per-bank OP code (PRE/ACT/RD/WR).
REQ-007 SHALL have ports b2a_addr, input, 4x13 (52): per-bank row/col address.
REQ-008 SHALL have ports b2a_id, input, 4xSDR_REQ_ID_W: per-bank request ID.
REQ-009 SHALL have ports b2a_len, input, 4xREQ_BW: per-bank transfer length.
REQ-010 SHALL have ports b2a_start, input, 4: per-bank first-chunk flag.
REQ-011 SHALL have ports b2a_last, input, 4: per-bank last-chunk flag.
REQ-012 SHALL have ports b2a_wrap, input, 4: per-bank wrap flag.
REQ-013 SHALL have port a2b_ack, output, 4: one-hot command-accepted to the bank FSMs.
REQ-014 SHALL have ports a2x_req, a2x_bank[1:0], a2x_cmd[1:0], a2x_addr[12:0], a2x_id, a2x_len, a2x_start, a2x_last, a2x_wrap, all outputs: the registered command presented to xfr_ctl.
REQ-015 SHALL have port x2a_ack, input, 1: xfr_ctl accepted the presented command.
REQ-016 SHALL have port x2a_refresh, input, 1: xfr_ctl is issuing a refresh.
REQ-017 SHALL have port age_limit, input, 4: starvation threshold; 0 disables aging.

Function
REQ-018 SHALL implement a two-state FSM: ARB_IDLE (no command presented) and ARB_BUSY (command presented, a2x_req=1).
REQ-019 SHALL, in ARB_IDLE with any b2a_req set, pick a winner round-robin starting at (rr_ptr+1) mod 4, register its fields onto the a2x_* outputs, and enter ARB_BUSY; a2x_req rises 1 cycle after the b2a_req.
REQ-020 SHALL hold all a2x_* outputs stable throughout ARB_BUSY until ack or abort.
REQ-021 SHALL, in ARB_BUSY with x2a_ack=1, drive a2b_ack[a2x_bank]=1 combinationally in that same cycle and set rr_ptr<=a2x_bank.
REQ-022 SHALL, on the ack cycle, pick the next winner among the other requesting banks, excluding the acked bank, and stay in ARB_BUSY with the new fields; if no other bank is requesting, return to ARB_IDLE. This gives back-to-back grants with no bubble.
REQ-023 SHALL abort when, in ARB_BUSY without x2a_ack, either b2a_req[a2x_bank]=0 or x2a_refresh=1: no a2b_ack, a2x_req=0 next cycle, enter ARB_IDLE, rr_ptr unchanged.
REQ-024 SHALL give x2a_ack priority when x2a_ack coincides with an abort condition: the command completes normally.
REQ-025 SHALL keep a2b_ack at 0 outside a qualified ack cycle, and a2b_ack SHALL be at most one-hot.
REQ-026 SHALL ignore x2a_ack while in ARB_IDLE.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, set state=ARB_IDLE, rr_ptr=3 (bank 0 wins first), a2x_req=0, all other a2x_* outputs=0, and aging counters=0.
REQ-028 SHALL, on reset asserted mid-ARB_BUSY, drop the presented command with no a2b_ack.

Configuration
REQ-029 SHALL, with SDRC_ARB_AGE_EN defined, keep a per-bank 4-bit wait counter: it increments (saturating at 15) each cycle the bank requests without being acked, and clears on its ack or when its request is low.
REQ-030 SHALL, with SDRC_ARB_AGE_EN defined and age_limit!=0, give absolute priority over round-robin to any bank whose counter is >= age_limit; among several such banks, the lowest index wins.
REQ-031 SHALL, with SDRC_ARB_AGE_EN undefined, omit the counters, keep the age_limit port present, and ignore it.

Structure
REQ-032 SHALL place the OP_PRE/OP_ACT/OP_RD/OP_WR codes, the ARB_IDLE/ARB_BUSY encodings and the bank count constant (4) in the shared sdrc define/package.
REQ-033 SHALL implement the rotating priority pick as sub-module sdrc_rr_pick (inputs: 4-bit request, 2-bit pointer, 4-bit exclude mask; outputs: valid, 2-bit index).

Verification
REQ-034 SHALL verify: b2a_req=4'b1111 continuously with x2a_ack every busy cycle -> a2x_bank sequence 0,1,2,3,0 and a2b_ack 0001,0010,0100,1000.
REQ-035 SHALL verify: bank 2 alone requests OP_ACT with addr 13'h0155 -> one cycle later a2x_req=1, a2x_cmd=ACT, a2x_addr=13'h0155; x2a_ack -> a2b_ack=4'b0100 in the same cycle, then ARB_IDLE.
REQ-036 SHALL verify: bank 1 in ARB_BUSY drops b2a_req before x2a_ack -> no a2b_ack, a2x_req=0 next cycle, and the next pick starts at bank 1 (rr_ptr unchanged).
REQ-037 SHALL verify: x2a_refresh and x2a_ack in the same cycle -> ack completes; x2a_refresh alone -> abort.
REQ-038 SHALL verify: reset asserted in ARB_BUSY -> a2x_req=0 and a2b_ack=0 on the next cycle, and the first post-reset grant goes to bank 0.
REQ-039 SHALL verify, with SDRC_ARB_AGE_EN and age_limit=3: bank 3 requests while x2a_ack is held low for 3 cycles -> bank 3 granted ahead of round-robin order; with age_limit=0 -> pure round-robin.
